// File: rtl/dcache_pkg.sv
// Shared types and sizes for the D-cache data-array access controller.
package dcache_pkg;

   localparam int DCACHE_WAYS       = 2;
   localparam int DCACHE_BANKS      = 8;
   localparam int DCACHE_DATA_WIDTH = 64;
   localparam int LINE_WIDTH        = DCACHE_BANKS * DCACHE_DATA_WIDTH;

   typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_REFILL, GNT_EVICT} gnt_e;
   typedef enum logic {RD_CORE, RD_EVICT} rd_kind_e;

   function automatic logic [1:0] way_onehot(input logic way);
      return way ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dcache_prio_arb.sv
// Fixed-priority arbiter (evict > refill > core) with a starvation override
// that hands the port to the core after STARVE_LIMIT consecutive losses.
module dcache_prio_arb
   import dcache_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic core_valid,
   input  logic refill_valid,
   input  logic evict_valid,
   output gnt_e gnt
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_cnt;
   logic [2:0] starve_cnt_next;

   // Grant is forced to none while reset is held so no handshake completes.
   always_comb begin
      gnt = GNT_NONE;
      if (!rst_n)
         gnt = GNT_NONE;
      else if (core_valid && (starve_cnt == LIMIT))
         gnt = GNT_CORE;
      else if (evict_valid)
         gnt = GNT_EVICT;
      else if (refill_valid)
         gnt = GNT_REFILL;
      else if (core_valid)
         gnt = GNT_CORE;
   end

   always_comb begin
      starve_cnt_next = starve_cnt;
      if (!core_valid || (gnt == GNT_CORE))
         starve_cnt_next = 3'd0;
      else if (starve_cnt != LIMIT)
         starve_cnt_next = starve_cnt + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= 3'd0;
      else
         starve_cnt <= starve_cnt_next;
   end

endmodule

// File: rtl/dcache_dataarray_ctrl.sv
// Shares the single D-cache data-array port between core, refill and evict,
// drives the array enables/addresses/data and returns read data one cycle later.
module dcache_dataarray_ctrl
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 9,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             core_req_valid,
   output logic                             core_req_ready,
   input  logic                             core_req_we,
   input  logic                             core_req_way,
   input  logic [ADDR_WIDTH-1:0]            core_req_set,
   input  logic [2:0]                       core_req_bank,
   input  logic [DATA_WIDTH-1:0]            core_req_wdata,
   input  logic [DATA_WIDTH-1:0]            core_req_wmask,
   output logic                             core_resp_valid,
   output logic [DATA_WIDTH-1:0]            core_resp_rdata,
   input  logic                             refill_valid,
   output logic                             refill_ready,
   input  logic                             refill_way,
   input  logic [ADDR_WIDTH-1:0]            refill_set,
   input  logic [DCACHE_BANKS*DATA_WIDTH-1:0] refill_data,
   input  logic                             evict_req_valid,
   output logic                             evict_req_ready,
   input  logic                             evict_way,
   input  logic [ADDR_WIDTH-1:0]            evict_set,
   output logic                             evict_resp_valid,
   output logic [DCACHE_BANKS*DATA_WIDTH-1:0] evict_resp_data,
   output logic [1:0]                       arr_ce_way,
   output logic                             arr_we,
   output logic [7:0]                       arr_ce_bank,
   output logic [ADDR_WIDTH-1:0]            arr_writesetaddr,
   output logic [ADDR_WIDTH-1:0]            arr_readsetaddr,
   output logic [DCACHE_BANKS*DATA_WIDTH-1:0] arr_din_bank,
   output logic [DCACHE_BANKS*DATA_WIDTH-1:0] arr_wmask_bank,
   input  logic [DCACHE_BANKS*DATA_WIDTH-1:0] arr_dout_bank
);

   localparam int LINE_W = DCACHE_BANKS * DATA_WIDTH;

   gnt_e        gnt;
   logic [LINE_W-1:0] core_din_line;
   logic [LINE_W-1:0] core_wmask_line;

   logic        rd_valid_q;
   rd_kind_e    rd_kind_q;
   logic [2:0]  rd_bank_q;

   dcache_prio_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk          (clock),
      .rst_n        (reset_n),
      .core_valid   (core_req_valid),
      .refill_valid (refill_valid),
      .evict_valid  (evict_req_valid),
      .gnt          (gnt)
   );

   assign core_req_ready  = (gnt == GNT_CORE);
   assign refill_ready    = (gnt == GNT_REFILL);
   assign evict_req_ready = (gnt == GNT_EVICT);

   // Store data goes to every lane; only the addressed bank gets a non-zero mask.
   genvar gi;
   generate
      for (gi = 0; gi < DCACHE_BANKS; gi++) begin : g_lane
         assign core_din_line[gi*DATA_WIDTH +: DATA_WIDTH]   = core_req_wdata;
         assign core_wmask_line[gi*DATA_WIDTH +: DATA_WIDTH] =
            (core_req_bank == 3'(gi)) ? core_req_wmask : '0;
      end
   endgenerate

   always_comb begin
      arr_ce_way       = 2'b00;
      arr_we           = 1'b0;
      arr_ce_bank      = 8'h00;
      arr_writesetaddr = '0;
      arr_readsetaddr  = '0;
      arr_din_bank     = '0;
      arr_wmask_bank   = '0;
      case (gnt)
         GNT_EVICT: begin
            arr_ce_way      = way_onehot(evict_way);
            arr_ce_bank     = 8'hFF;
            arr_readsetaddr = evict_set;
         end
         GNT_REFILL: begin
            arr_ce_way       = way_onehot(refill_way);
            arr_ce_bank      = 8'hFF;
            arr_we           = 1'b1;
            arr_writesetaddr = refill_set;
            arr_din_bank     = refill_data;
            arr_wmask_bank   = '1;
         end
         GNT_CORE: begin
            arr_ce_way  = way_onehot(core_req_way);
            arr_ce_bank = 8'h01 << core_req_bank;
            arr_we      = core_req_we;
            if (core_req_we) begin
               arr_writesetaddr = core_req_set;
               arr_din_bank     = core_din_line;
               arr_wmask_bank   = core_wmask_line;
            end else begin
               arr_readsetaddr = core_req_set;
            end
         end
         default: ;
      endcase
   end

   // Array data arrives the cycle after a read enable; remember who asked.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_kind_q  <= RD_CORE;
         rd_bank_q  <= 3'd0;
      end else begin
         rd_valid_q <= (gnt == GNT_EVICT) || ((gnt == GNT_CORE) && !core_req_we);
         rd_kind_q  <= (gnt == GNT_EVICT) ? RD_EVICT : RD_CORE;
         rd_bank_q  <= core_req_bank;
      end
   end

   assign core_resp_valid  = rd_valid_q && (rd_kind_q == RD_CORE);
   assign evict_resp_valid = rd_valid_q && (rd_kind_q == RD_EVICT);
   assign core_resp_rdata  = core_resp_valid ? arr_dout_bank[rd_bank_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign evict_resp_data  = evict_resp_valid ? arr_dout_bank : '0;

endmodule

// File: tb/tb_dcache_dataarray_ctrl.sv
// Directed bench for dcache_dataarray_ctrl with a behavioural 2-way x 8-bank array
// and a response scoreboard.
module tb_dcache_dataarray_ctrl;
   import dcache_pkg::*;

   localparam int DW = 64;
   localparam int AW = 9;
   localparam int LW = 8 * DW;

   logic          clock;
   logic          reset_n;
   logic          core_req_valid, core_req_ready, core_req_we, core_req_way;
   logic [AW-1:0] core_req_set;
   logic [2:0]    core_req_bank;
   logic [DW-1:0] core_req_wdata, core_req_wmask;
   logic          core_resp_valid;
   logic [DW-1:0] core_resp_rdata;
   logic          refill_valid, refill_ready, refill_way;
   logic [AW-1:0] refill_set;
   logic [LW-1:0] refill_data;
   logic          evict_req_valid, evict_req_ready, evict_way;
   logic [AW-1:0] evict_set;
   logic          evict_resp_valid;
   logic [LW-1:0] evict_resp_data;
   logic [1:0]    arr_ce_way;
   logic          arr_we;
   logic [7:0]    arr_ce_bank;
   logic [AW-1:0] arr_writesetaddr, arr_readsetaddr;
   logic [LW-1:0] arr_din_bank, arr_wmask_bank, arr_dout_bank;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] core_q[$];
   logic [LW-1:0] evict_q[$];

   logic [DW-1:0] mem [0:1][0:511][0:7];

   dcache_dataarray_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
      .core_req_we(core_req_we), .core_req_way(core_req_way),
      .core_req_set(core_req_set), .core_req_bank(core_req_bank),
      .core_req_wdata(core_req_wdata), .core_req_wmask(core_req_wmask),
      .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
      .refill_valid(refill_valid), .refill_ready(refill_ready),
      .refill_way(refill_way), .refill_set(refill_set), .refill_data(refill_data),
      .evict_req_valid(evict_req_valid), .evict_req_ready(evict_req_ready),
      .evict_way(evict_way), .evict_set(evict_set),
      .evict_resp_valid(evict_resp_valid), .evict_resp_data(evict_resp_data),
      .arr_ce_way(arr_ce_way), .arr_we(arr_we), .arr_ce_bank(arr_ce_bank),
      .arr_writesetaddr(arr_writesetaddr), .arr_readsetaddr(arr_readsetaddr),
      .arr_din_bank(arr_din_bank), .arr_wmask_bank(arr_wmask_bank),
      .arr_dout_bank(arr_dout_bank)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] init_word(input int w, input int s, input int b);
      return {48'hA5A5_0000_0000, 3'b000, 1'(w), 9'(s), 3'(b)};
   endfunction

   function automatic logic [LW-1:0] init_line(input int w, input int s);
      logic [LW-1:0] l;
      for (int b = 0; b < 8; b++) l[b*DW +: DW] = init_word(w, s, b);
      return l;
   endfunction

   initial begin
      arr_dout_bank = '0;
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 512; s++)
            for (int b = 0; b < 8; b++)
               mem[w][s][b] = init_word(w, s, b);
   end

   // Behavioural SRAM: writes land at the edge, read data is registered.
   always @(posedge clock) begin
      if (arr_ce_way != 2'b00) begin
         for (int b = 0; b < 8; b++) begin
            if (arr_ce_bank[b]) begin
               if (arr_we)
                  mem[arr_ce_way[1]][arr_writesetaddr][b] =
                     (mem[arr_ce_way[1]][arr_writesetaddr][b] & ~arr_wmask_bank[b*DW +: DW]) |
                     (arr_din_bank[b*DW +: DW] & arr_wmask_bank[b*DW +: DW]);
               else
                  arr_dout_bank[b*DW +: DW] <= mem[arr_ce_way[1]][arr_readsetaddr][b];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Scoreboard monitor: pops an expectation whenever the DUT presents a response.
   initial begin
      forever begin
         @(negedge clock);
         if (core_resp_valid) begin
            if (core_q.size() == 0) chk("core_resp_unexpected", 512'(1), 512'(0));
            else chk("core_resp", 512'(core_resp_rdata), 512'(core_q.pop_front()));
         end
         if (evict_resp_valid) begin
            if (evict_q.size() == 0) chk("evict_resp_unexpected", 512'(1), 512'(0));
            else chk("evict_resp", evict_resp_data, evict_q.pop_front());
         end
      end
   end

   task automatic idle();
      core_req_valid = 0; core_req_we = 0; core_req_way = 0; core_req_set = '0;
      core_req_bank = '0; core_req_wdata = '0; core_req_wmask = '0;
      refill_valid = 0; refill_way = 0; refill_set = '0; refill_data = '0;
      evict_req_valid = 0; evict_way = 0; evict_set = '0;
   endtask

   task automatic core_req(input logic we, input logic way, input int set, input int bank,
                           input logic [DW-1:0] wd, input logic [DW-1:0] wm);
      core_req_valid = 1; core_req_we = we; core_req_way = way; core_req_set = 9'(set);
      core_req_bank = 3'(bank); core_req_wdata = wd; core_req_wmask = wm;
   endtask

   logic [LW-1:0] rl, l2, l9, exp_line, full_mask;

   initial begin
      full_mask = '1;
      for (int b = 0; b < 8; b++) begin
         rl[b*DW +: DW] = 64'(b);
         l2[b*DW +: DW] = 64'h2222_0000_0000_0000 + 64'(b);
         l9[b*DW +: DW] = 64'h9999_0000_0000_0000 + 64'(b);
      end
      reset_n = 1'b0;
      idle();
      repeat (2) @(negedge clock);

      // Reset held with every requester asserting
      core_req_valid = 1; refill_valid = 1; evict_req_valid = 1;
      core_req_way = 1; refill_way = 1; evict_way = 1;
      #1;
      chk("rst_readies", 512'({core_req_ready, refill_ready, evict_req_ready}), 512'(0));
      chk("rst_ce_way", 512'(arr_ce_way), 512'(0));
      chk("rst_ce_bank_we", 512'({arr_ce_bank, arr_we}), 512'(0));
      chk("rst_din_wmask", arr_din_bank | arr_wmask_bank, 512'(0));
      chk("rst_resp_valids", 512'({core_resp_valid, evict_resp_valid}), 512'(0));
      idle();
      @(negedge clock); reset_n = 1'b1;

      // Core store way1/set5/bank3 then load it back
      @(negedge clock); core_req(1, 1, 5, 3, 64'h0000_0000_DEAD_BEEF, '1); #1;
      chk("st_ready", 512'(core_req_ready), 512'(1));
      chk("st_ce_way", 512'(arr_ce_way), 512'(2'b10));
      chk("st_ce_bank", 512'(arr_ce_bank), 512'(8'h08));
      chk("st_we_wsa", 512'({arr_we, arr_writesetaddr, arr_readsetaddr}), 512'({1'b1, 9'd5, 9'd0}));
      chk("st_din", arr_din_bank, {8{64'h0000_0000_DEAD_BEEF}});
      chk("st_wmask", arr_wmask_bank, 512'({64{1'b1}}) << 192);
      @(negedge clock); core_req(0, 1, 5, 3, '0, '0); #1;
      chk("ld_ce", 512'({arr_ce_way, arr_ce_bank, arr_we}), 512'({2'b10, 8'h08, 1'b0}));
      chk("ld_rsa", 512'({arr_readsetaddr, arr_writesetaddr}), 512'({9'd5, 9'd0}));
      chk("ld_wmask", arr_wmask_bank, 512'(0));
      core_q.push_back(64'h0000_0000_DEAD_BEEF);

      // Refill way0/set7 then evict it
      @(negedge clock); idle(); refill_valid = 1; refill_way = 0; refill_set = 9'd7; refill_data = rl; #1;
      chk("rf_ready", 512'(refill_ready), 512'(1));
      chk("rf_ce", 512'({arr_ce_way, arr_ce_bank, arr_we, arr_writesetaddr}), 512'({2'b01, 8'hFF, 1'b1, 9'd7}));
      chk("rf_din", arr_din_bank, rl);
      chk("rf_wmask", arr_wmask_bank, full_mask);
      @(negedge clock); idle(); evict_req_valid = 1; evict_way = 0; evict_set = 9'd7; #1;
      chk("ev_ready", 512'(evict_req_ready), 512'(1));
      chk("ev_ce", 512'({arr_ce_way, arr_ce_bank, arr_we, arr_readsetaddr}), 512'({2'b01, 8'hFF, 1'b0, 9'd7}));
      evict_q.push_back(rl);

      // Evict and refill of way1/set2 collide: evict goes first and sees the old line
      @(negedge clock); idle();
      evict_req_valid = 1; evict_way = 1; evict_set = 9'd2;
      refill_valid = 1; refill_way = 1; refill_set = 9'd2; refill_data = l2; #1;
      chk("col_readies", 512'({evict_req_ready, refill_ready, arr_we}), 512'({1'b1, 1'b0, 1'b0}));
      evict_q.push_back(init_line(1, 2));
      @(negedge clock); evict_req_valid = 0; #1;
      chk("col_refill_next", 512'({refill_ready, arr_we, arr_ce_way}), 512'({1'b1, 1'b1, 2'b10}));
      @(negedge clock); idle(); evict_req_valid = 1; evict_way = 1; evict_set = 9'd2; #1;
      chk("col_ev2_ready", 512'(evict_req_ready), 512'(1));
      evict_q.push_back(l2);

      // Core load starved by continuous refills wins on the 5th cycle
      @(negedge clock); idle();
      core_req(0, 1, 5, 3, '0, '0);
      refill_valid = 1; refill_way = 0; refill_set = 9'd9; refill_data = l9;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clock);
         #1;
         chk($sformatf("starve_c%0d_core_ready", k), 512'(core_req_ready), 512'(k == 5));
         chk($sformatf("starve_c%0d_refill_ready", k), 512'(refill_ready), 512'(k != 5));
         if (k == 5) core_q.push_back(64'h0000_0000_DEAD_BEEF);
      end

      // Partial-mask store, then readback and a full-line check of the other banks
      @(negedge clock); idle(); core_req(1, 1, 5, 3, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_0000); #1;
      chk("mst_ready", 512'(core_req_ready), 512'(1));
      chk("mst_wmask", arr_wmask_bank, 512'(64'h0000_0000_FFFF_0000) << 192);
      @(negedge clock); core_req(0, 1, 5, 3, '0, '0); #1;
      core_q.push_back(64'h0000_0000_9ABC_BEEF);
      @(negedge clock); core_req(0, 1, 5, 2, '0, '0); #1;
      core_q.push_back(init_word(1, 5, 2));
      @(negedge clock); idle(); evict_req_valid = 1; evict_way = 1; evict_set = 9'd5; #1;
      exp_line = init_line(1, 5);
      exp_line[3*DW +: DW] = 64'h0000_0000_9ABC_BEEF;
      evict_q.push_back(exp_line);

      // Reset during the response cycle of a load drops the response
      @(negedge clock); idle(); core_req(0, 1, 5, 2, '0, '0); #1;
      chk("rl_ready", 512'(core_req_ready), 512'(1));
      @(posedge clock); #1; reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock); #1;
         chk($sformatf("rl_c%0d_resp_valid", k), 512'({core_resp_valid, evict_resp_valid}), 512'(0));
         chk($sformatf("rl_c%0d_arr", k), 512'({arr_ce_way, arr_ce_bank, arr_we, core_req_ready}), 512'(0));
      end
      @(negedge clock); idle(); reset_n = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk("core_q_drained", 512'(core_q.size()), 512'(0));
      chk("evict_q_drained", 512'(evict_q.size()), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache_dataarray_ctrl.md
# dcache_dataarray_ctrl

Access sequencer and arbiter in front of the 2-way, 8-bank D-cache data array. Three requesters share the single array port: core load/store (one 64-bit bank), refill (full 512-bit line write), and evict (full-line read of a victim). The block grants at most one array access per cycle, drives the array's way/bank enables, set addresses, data and masks, and returns read data one cycle after grant.

## Interface
- DATA_WIDTH, 64, bank word width
- ADDR_WIDTH, 9, set index width
- STARVE_LIMIT, 4, consecutive lost core cycles before the core is forced to win (1..7)
- clock  in  1  single clock, all state on posedge
- reset_n  in  1  reset, asynchronous, active-low
- core_req_valid / core_req_ready  in / out  1  core handshake
- core_req_we  in  1  1 = store, 0 = load
- core_req_way  in  1  target way
- core_req_set  in  ADDR_WIDTH  set index
- core_req_bank  in  3  bank select
- core_req_wdata / core_req_wmask  in  DATA_WIDTH  store data, bit mask
- core_resp_valid  out  1  load data valid, no backpressure
- core_resp_rdata  out  DATA_WIDTH  load data
- refill_valid / refill_ready  in / out  1  refill handshake
- refill_way  in  1;  refill_set  in  ADDR_WIDTH;  refill_data  in  8*DATA_WIDTH  line, bank i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- evict_req_valid / evict_req_ready  in / out  1  evict handshake
- evict_way  in  1;  evict_set  in  ADDR_WIDTH
- evict_resp_valid  out  1;  evict_resp_data  out  8*DATA_WIDTH  victim line
- arr_ce_way  out  2;  arr_we  out  1;  arr_ce_bank  out  8
- arr_writesetaddr / arr_readsetaddr  out  ADDR_WIDTH
- arr_din_bank / arr_wmask_bank  out  DATA_WIDTH x 8
- arr_dout_bank  in  DATA_WIDTH x 8  array read data, valid one cycle after a read-enable

## Operation
- One grant per cycle. Readies are combinational from valids and the starvation counter; the transfer happens when valid & ready.
- Priority: evict > refill > core. Override: when starve_cnt == STARVE_LIMIT and core_req_valid, the core wins over both.
- starve_cnt (3 bits): increments when core_req_valid & ~core_req_ready, saturating at STARVE_LIMIT. Clears on a core grant or when core_req_valid is low.
- Evict grant: arr_ce_way = onehot(evict_way), arr_ce_bank = 8'hFF, arr_we = 0, arr_readsetaddr = evict_set.
- Refill grant: onehot way, all banks, arr_we = 1, arr_writesetaddr = refill_set, din = line slices, wmask = all ones.
- Core store: onehot way, arr_ce_bank = onehot(bank), arr_we = 1. wdata is replicated to all din lanes. wmask goes only on the selected bank; all other lanes are 0.
- Core load: same as a store with arr_we = 0 and arr_readsetaddr = core_req_set.
- Idle or unused fields are driven to 0. arr_ce_way is never 2'b11.
- Read pipeline register: rd_valid_q, rd_kind_q (core/evict), rd_bank_q.
  - Next cycle with core kind: core_resp_valid = 1, core_resp_rdata = arr_dout_bank[rd_bank_q].
  - Next cycle with evict kind: evict_resp_valid = 1, evict_resp_data = concatenation of all 8 banks.
- Same set/way contention is resolved purely by priority:
  - Evict + refill in the same cycle: the evict reads the old victim; the refill writes the next cycle.
  - Refill + core load in the same cycle: the core is granted later and reads the refilled data.

## Timing
- Request to array enable: combinational, same cycle.
- Load/evict response: exactly 1 cycle after grant. Back-to-back reads give back-to-back responses.
- Write: completes at the grant edge; a read granted in the following cycle returns the new data.
- Reset: all state and outputs go to 0, including readies, resp_valids and arr_* signals.
- Reset asserted mid-read drops the pending response; no resp_valid follows reset.
- Starvation bound: with continuous evict/refill traffic, a core request is granted within STARVE_LIMIT+1 cycles.

## Structure
- Package dcache_pkg holds:
  - DCACHE_WAYS = 2, DCACHE_BANKS = 8, LINE_WIDTH = DCACHE_BANKS*DATA_WIDTH
  - enum gnt_e {GNT_NONE, GNT_CORE, GNT_REFILL, GNT_EVICT}
  - enum rd_kind_e {RD_CORE, RD_EVICT}
- Sub-module dcache_prio_arb: 3-input fixed-priority arbiter with starvation override. It contains starve_cnt and outputs gnt_e.
- Top level: array-side muxing and the read pipeline register.

## Test plan
- Core store way1/set 5/bank 3, data 0xDEAD_BEEF, mask all ones; load the same next cycle -> arr_ce_bank = 8'h08, arr_ce_way = 2'b10; core_resp_rdata = 0xDEAD_BEEF, 1 cycle after load grant.
- Refill way0/set 7, line with bank i = i, then evict way0/set 7 -> evict_resp_data bank i = i; evict_resp_valid one cycle after evict grant.
- Evict and refill to set 2/way1 in the same cycle -> evict granted first, returns pre-refill line; refill_ready high the next cycle.
- Core load held valid under continuous refill traffic -> core_req_ready rises exactly on the 5th cycle (STARVE_LIMIT = 4); starve_cnt then clears.
- Core store with mask 0x0000_0000_FFFF_0000 -> only those bits change on readback; other banks untouched.
- Assert reset_n low during the response cycle of a load -> no core_resp_valid; all arr_* = 0 until release.
